// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock-qualification sequencer running on the free-running refclk.
// Pulses the PLL reset, debounces lock, releases domain resets in order, and recovers on loss/timeout.
module pll_reset_sequencer #(
   parameter int unsigned RST_CYCLES          = 16,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 500000,
   parameter int unsigned NUM_DOMAINS         = 3,
   parameter int unsigned RELEASE_GAP         = 8
) (
   input  logic                   refclk,
   input  logic                   rst,
   input  logic                   pll_locked,
   input  logic                   force_relock,
   output logic                   pll_rst,
   output logic [NUM_DOMAINS-1:0] dom_rst,
   output logic                   ready,
   output logic [7:0]             retry_count,
   output logic                   timeout_err
);

   localparam int unsigned REL_LAST = (NUM_DOMAINS > 1) ? RELEASE_GAP * (NUM_DOMAINS - 1) : 1;
   localparam int unsigned SEQ_MAX  = (RST_CYCLES > REL_LAST) ? RST_CYCLES : REL_LAST;
   localparam int unsigned SEQ_W    = $clog2(SEQ_MAX + 1);
   localparam int unsigned STB_W    = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int unsigned TMO_W    = $clog2(LOCK_TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {RESET_PLL, WAIT_LOCK, RELEASE, RUN} state_t;

   state_t                 state, state_nxt;
   logic [SEQ_W-1:0]       seq_cnt, seq_cnt_nxt, seq_c;
   logic [STB_W-1:0]       stb_cnt, stb_cnt_nxt;
   logic [TMO_W-1:0]       tmo_cnt, tmo_cnt_nxt;
   logic                   sync1, locked_s;
   logic                   restart;
   logic                   pll_rst_nxt, ready_nxt, timeout_err_nxt;
   logic [NUM_DOMAINS-1:0] dom_rst_nxt;
   logic [7:0]             retry_count_nxt;

   // Two-flop synchronizer for the asynchronous lock indication
   always_ff @(posedge refclk) begin
      if (rst) begin
         sync1    <= 1'b0;
         locked_s <= 1'b0;
      end else begin
         sync1    <= pll_locked;
         locked_s <= sync1;
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge refclk) begin
      if (rst) begin
         state       <= RESET_PLL;
         seq_cnt     <= '0;
         stb_cnt     <= '0;
         tmo_cnt     <= '0;
         pll_rst     <= 1'b1;
         dom_rst     <= '1;
         ready       <= 1'b0;
         retry_count <= 8'd0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         seq_cnt     <= seq_cnt_nxt;
         stb_cnt     <= stb_cnt_nxt;
         tmo_cnt     <= tmo_cnt_nxt;
         pll_rst     <= pll_rst_nxt;
         dom_rst     <= dom_rst_nxt;
         ready       <= ready_nxt;
         retry_count <= retry_count_nxt;
         timeout_err <= timeout_err_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt       = state;
      seq_cnt_nxt     = seq_cnt;
      stb_cnt_nxt     = stb_cnt;
      tmo_cnt_nxt     = tmo_cnt;
      pll_rst_nxt     = pll_rst;
      dom_rst_nxt     = dom_rst;
      ready_nxt       = ready;
      retry_count_nxt = retry_count;
      timeout_err_nxt = timeout_err;
      seq_c           = seq_cnt + SEQ_W'(1);
      restart         = 1'b0;

      case (state)
         RESET_PLL: begin
            stb_cnt_nxt = '0;
            tmo_cnt_nxt = '0;
            if (force_relock) begin
               restart = 1'b1;
            end else if (seq_cnt == SEQ_W'(RST_CYCLES - 1)) begin
               state_nxt   = WAIT_LOCK;
               seq_cnt_nxt = '0;
               pll_rst_nxt = 1'b0;
            end else begin
               seq_cnt_nxt = seq_c;
            end
         end
         WAIT_LOCK: begin
            if (force_relock) begin
               restart = 1'b1;
            end else begin
               tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
               stb_cnt_nxt = locked_s ? stb_cnt + STB_W'(1) : '0;
               // Qualified lock takes priority over a coincident timeout
               if (locked_s && (stb_cnt == STB_W'(LOCK_STABLE_CYCLES - 1))) begin
                  state_nxt      = RELEASE;
                  seq_cnt_nxt    = '0;
                  dom_rst_nxt[0] = 1'b0;
               end else if (tmo_cnt == TMO_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                  restart         = 1'b1;
                  timeout_err_nxt = 1'b1;
               end
            end
         end
         RELEASE: begin
            if (!locked_s || force_relock) begin
               restart = 1'b1;
            end else begin
               seq_cnt_nxt = seq_c;
               for (int i = 1; i < NUM_DOMAINS; i++) begin
                  if (seq_c == SEQ_W'(RELEASE_GAP * i)) dom_rst_nxt[i] = 1'b0;
               end
               if (seq_c == SEQ_W'(REL_LAST)) begin
                  state_nxt = RUN;
                  ready_nxt = 1'b1;
               end
            end
         end
         RUN: begin
            if (!locked_s || force_relock) restart = 1'b1;
         end
         default: restart = 1'b1;
      endcase

      // Any recovery re-enters RESET_PLL with everything held in reset
      if (restart) begin
         state_nxt   = RESET_PLL;
         seq_cnt_nxt = '0;
         stb_cnt_nxt = '0;
         tmo_cnt_nxt = '0;
         pll_rst_nxt = 1'b1;
         dom_rst_nxt = '1;
         ready_nxt   = 1'b0;
         if (retry_count != 8'hFF) retry_count_nxt = retry_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed plus random lock/force stimulus
// against a timeline-based reference model (sequence start edge, release edge, retry tally).
module tb_pll_reset_sequencer;

   localparam int R   = 4;
   localparam int LSC = 8;
   localparam int LTC = 64;
   localparam int N   = 3;
   localparam int GAP = 2;

   logic         refclk = 1'b0;
   logic         rst = 1'b1;
   logic         pll_locked = 1'b0;
   logic         force_relock = 1'b0;
   logic         pll_rst;
   logic [N-1:0] dom_rst;
   logic         ready;
   logic [7:0]   retry_count;
   logic         timeout_err;

   int checks = 0;
   int errors = 0;

   // model state: edge index, start edge of current sequence, release edge (-1 if none)
   int e = 0, s = 0, r = -1, run_len = 0, retries = 0;
   bit terr = 1'b0, q1 = 1'b0, q2 = 1'b0;
   logic [N-1:0] exp_dom;
   logic         exp_pll, exp_ready;

   always #10 refclk = ~refclk;

   pll_reset_sequencer #(
      .RST_CYCLES(R), .LOCK_STABLE_CYCLES(LSC), .LOCK_TIMEOUT_CYCLES(LTC),
      .NUM_DOMAINS(N), .RELEASE_GAP(GAP)
   ) dut (
      .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .force_relock(force_relock),
      .pll_rst(pll_rst), .dom_rst(dom_rst), .ready(ready),
      .retry_count(retry_count), .timeout_err(timeout_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance the reference timeline by one edge using the inputs present before it
   function automatic void model_edge();
      bit ls, restart;
      e++;
      ls = q2;
      restart = 1'b0;
      if (rst) begin
         s = e; r = -1; run_len = 0; retries = 0; terr = 1'b0;
      end else if (r < 0) begin
         if (e <= s + R) begin
            if (force_relock) restart = 1'b1;
         end else if (force_relock) begin
            restart = 1'b1;
         end else begin
            run_len = ls ? run_len + 1 : 0;
            if (run_len == LSC) r = e;
            else if (e - (s + R) == LTC) begin
               restart = 1'b1; terr = 1'b1;
            end
         end
      end else if (!ls || force_relock) begin
         restart = 1'b1;
      end
      if (restart) begin
         s = e; r = -1; run_len = 0;
         if (retries < 255) retries++;
      end
      if (rst) begin q1 = 1'b0; q2 = 1'b0; end
      else begin q2 = q1; q1 = pll_locked; end
      exp_pll   = (r < 0) && (e < s + R);
      exp_ready = (r >= 0) && (e >= r + GAP * (N - 1));
      for (int i = 0; i < N; i++) exp_dom[i] = !((r >= 0) && (e >= r + GAP * i));
   endfunction

   task automatic tick();
      model_edge();
      @(posedge refclk);
      #1;
      chk("pll_rst", 32'(pll_rst), 32'(exp_pll));
      chk("dom_rst", 32'(dom_rst), 32'(exp_dom));
      chk("ready", 32'(ready), 32'(exp_ready));
      chk("retry_count", 32'(retry_count), 32'(retries));
      chk("timeout_err", 32'(timeout_err), 32'(terr));
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int found;
      // reset state
      ticks(3);
      chk("reset_dom_rst", 32'(dom_rst), 32'h7);
      chk("reset_pll_rst", 32'(pll_rst), 32'h1);

      // clean start: lock from cycle 10
      rst = 1'b0;
      ticks(10);
      pll_locked = 1'b1;
      ticks(30);
      chk("clean_ready", 32'(ready), 32'h1);
      chk("clean_retry", 32'(retry_count), 32'h0);

      // lock glitch during qualification
      rst = 1'b1; pll_locked = 1'b0;
      tick();
      rst = 1'b0;
      ticks(6);
      pll_locked = 1'b1; ticks(6);
      pll_locked = 1'b0; tick();
      pll_locked = 1'b1; ticks(30);
      chk("glitch_ready", 32'(ready), 32'h1);
      chk("glitch_retry", 32'(retry_count), 32'h0);

      // lock loss in RUN
      pll_locked = 1'b0; ticks(3);
      chk("loss_dom_rst", 32'(dom_rst), 32'h7);
      chk("loss_retry", 32'(retry_count), 32'h1);
      pll_locked = 1'b1; ticks(30);
      chk("relock_ready", 32'(ready), 32'h1);

      // force_relock coincident with synchronized lock loss
      pll_locked = 1'b0; ticks(2);
      force_relock = 1'b1; tick();
      force_relock = 1'b0;
      chk("dual_retry", 32'(retry_count), 32'h2);
      chk("dual_pll_rst", 32'(pll_rst), 32'h1);
      pll_locked = 1'b1; ticks(30);

      // random lock toggling and force pulses
      for (int ep = 0; ep < 40; ep++) begin
         pll_locked = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < int'($urandom_range(1, 24)); k++) begin
            force_relock = ($urandom_range(0, 15) == 0);
            tick();
         end
         force_relock = 1'b0;
      end

      // timeouts until retry_count saturates
      pll_locked = 1'b0;
      ticks(256 * (R + LTC) + 10);
      chk("sat_retry", 32'(retry_count), 32'hFF);
      chk("sat_timeout_err", 32'(timeout_err), 32'h1);

      // rst in the middle of RELEASE
      pll_locked = 1'b1;
      found = 0;
      for (int k = 0; k < 200 && found == 0; k++) begin
         tick();
         if (exp_dom == 3'b110) found = 1;
      end
      chk("reach_release", 32'(found), 32'h1);
      rst = 1'b1; tick();
      chk("midrst_dom_rst", 32'(dom_rst), 32'h7);
      chk("midrst_pll_rst", 32'(pll_rst), 32'h1);
      chk("midrst_retry", 32'(retry_count), 32'h0);
      chk("midrst_timeout_err", 32'(timeout_err), 32'h0);
      rst = 1'b0;
      ticks(40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
